keccak_sponge_ctrl: RTL

Sequencing controller for the Keccak-f[1600] datapath (SHA3-512 profile, rate 576 bits = 9 lanes of 64 bits).
- Accepts message words with a byte count on the last word and buffers them into a rate block.
- Applies pad10*1 padding, issues a one-cycle absorb to the state datapath, then steps the datapath through 24 rounds.
- Flags when the 1600-bit state holds the final hash.
- Sits between the message source and the round/state datapath. Holds no Keccak state itself.

---
 rtl/keccak_sponge_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/keccak_sponge_ctrl.sv
// Keccak-f[1600] sponge sequencer: buffers/pads rate blocks, drives absorb and rounds.
// Optional KECCAK_SHA3_PAD_EN selects the SHA-3 domain pad byte 0x06 instead of 0x01.
module keccak_sponge_ctrl #(
    parameter int RATE_WORDS = 9,
    parameter int ROUNDS     = 24,
    parameter int WORD_W     = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [WORD_W-1:0]            in_data,
    input  logic                         in_ready,
    input  logic                         is_last,
    input  logic [2:0]                   byte_num,
    output logic                         buffer_full,
    output logic [RATE_WORDS*WORD_W-1:0] blk_data,
    output logic                         absorb,
    output logic                         state_clr,
    output logic                         round_en,
    output logic [4:0]                   round_idx,
    output logic                         out_ready
);

    localparam int CW = $clog2(RATE_WORDS + 1);
    localparam logic [CW-1:0] LAST_LANE = CW'(RATE_WORDS - 1);
    localparam logic [4:0]    LAST_RND  = 5'(ROUNDS - 1);
    localparam int            TOP_OFS   = (RATE_WORDS - 1) * WORD_W;
`ifdef KECCAK_SHA3_PAD_EN
    localparam logic [7:0]    PAD_BYTE  = 8'h06;
`else
    localparam logic [7:0]    PAD_BYTE  = 8'h01;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_ABSORB,
        S_ROUND,
        S_DONE
    } state_t;

    state_t                         r_state;
    logic [RATE_WORDS*WORD_W-1:0]   r_blk;
    logic [CW-1:0]                  r_cnt;
    logic                           r_final;
    logic [4:0]                     r_round;

    state_t                         w_state_nxt;
    logic [RATE_WORDS*WORD_W-1:0]   w_blk_nxt;
    logic [CW-1:0]                  w_cnt_nxt;
    logic                           w_final_nxt;
    logic [4:0]                     w_round_nxt;
    logic                           w_accept;
    logic                           w_start;
    logic [CW-1:0]                  w_idx;
    logic [5:0]                     w_shift;
    logic [WORD_W-1:0]              w_keep;
    logic [WORD_W-1:0]              w_pad;
    logic [WORD_W-1:0]              w_lane;

    assign buffer_full = (r_state == S_ABSORB) || (r_state == S_ROUND);
    assign absorb      = (r_state == S_ABSORB);
    assign round_en    = (r_state == S_ROUND);
    assign out_ready   = (r_state == S_DONE);
    assign round_idx   = r_round;
    assign blk_data    = r_blk;

    assign w_accept = in_ready && !buffer_full;
    assign w_start  = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_idx    = w_start ? '0 : r_cnt;

    // Byte 0 sits in the MSBs, so valid bytes are the top 8*byte_num bits.
    assign w_shift = {byte_num, 3'b000};
    assign w_keep  = ~({WORD_W{1'b1}} >> w_shift);
    assign w_pad   = {{(WORD_W-8){1'b0}}, PAD_BYTE} << (6'd56 - w_shift);
    assign w_lane  = is_last ? ((in_data & w_keep) | w_pad) : in_data;

    always_comb begin
        w_state_nxt = r_state;
        w_blk_nxt   = r_blk;
        w_cnt_nxt   = r_cnt;
        w_final_nxt = r_final;
        w_round_nxt = r_round;
        state_clr   = 1'b0;

        unique case (r_state)
            S_IDLE, S_DONE, S_FILL: begin
                if (w_accept) begin
                    state_clr = w_start;
                    for (int i = 0; i < RATE_WORDS; i++) begin
                        if (w_idx == CW'(i))
                            w_blk_nxt[i*WORD_W +: WORD_W] = w_lane;
                    end
                    w_cnt_nxt = w_idx + 1'b1;
                    if (is_last) begin
                        // Closing 1-bit of pad10*1; merges with the start byte when coincident.
                        w_blk_nxt[TOP_OFS +: 8] = w_blk_nxt[TOP_OFS +: 8] | 8'h80;
                        w_final_nxt = 1'b1;
                        w_state_nxt = S_ABSORB;
                    end else if (w_idx == LAST_LANE) begin
                        w_state_nxt = S_ABSORB;
                    end else begin
                        w_state_nxt = S_FILL;
                    end
                end
            end
            S_ABSORB: begin
                w_round_nxt = '0;
                w_state_nxt = S_ROUND;
            end
            S_ROUND: begin
                if (r_round == LAST_RND) begin
                    w_round_nxt = '0;
                    w_blk_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_final_nxt = 1'b0;
                    w_state_nxt = r_final ? S_DONE : S_FILL;
                end else begin
                    w_round_nxt = r_round + 5'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_blk   <= '0;
            r_cnt   <= '0;
            r_final <= 1'b0;
            r_round <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_blk   <= w_blk_nxt;
            r_cnt   <= w_cnt_nxt;
            r_final <= w_final_nxt;
            r_round <= w_round_nxt;
        end
    end

endmodule
